// File: rtl/mips_pkg.sv
// Shared MIPS encodings and the control bundle carried from the decoder to the register stage.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  typedef struct packed {
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       reg_write;
    logic       jump;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/funct decode table producing the datapath control bundle.
module control_decode
  import mips_pkg::*;
(
  input  logic [5:0] op_code,
  input  logic [5:0] funct,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl        = '0;
    ctrl.alu_op = ALUOP_ADD;
    // funct is only examined inside the R-type arm, so an undefined funct
    // cannot leak into the outputs of any other instruction.
    case (op_code)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_SUB, F_AND, F_OR, F_SLT: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_op    = ALUOP_RTYPE;
          end
          default: ctrl.illegal = 1'b1;
        endcase
      end
      OP_LW: begin
        ctrl.mem_read   = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
      end
      OP_SW:   ctrl.mem_write = 1'b1;
      OP_BEQ:  ctrl.alu_op    = ALUOP_SUB;
      OP_J:    ctrl.jump      = 1'b1;
      default: ctrl.illegal   = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Main MIPS control unit: table decode followed by one registered stage.
module control_unit
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic       mem_read,
  output logic       mem_to_reg,
  output logic       mem_write,
  output logic       reg_write,
  output logic       jump,
  output logic [1:0] ALU_op,
  output logic       illegal,
  input  logic [5:0] op_code,
  input  logic [5:0] funct
);

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  control_decode u_decode (
    .op_code (op_code),
    .funct   (funct),
    .ctrl    (ctrl_d)
  );

  // No handshake: a fresh instruction is accepted every cycle and its decode
  // is visible on the outputs for exactly the following clock period.
  always_ff @(posedge clk) begin
    if (!rst_n) ctrl_q <= '0;
    else        ctrl_q <= ctrl_d;
  end

  assign mem_read   = ctrl_q.mem_read;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign mem_write  = ctrl_q.mem_write;
  assign reg_write  = ctrl_q.reg_write;
  assign jump       = ctrl_q.jump;
  assign ALU_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table-driven reference model, expected queue, per-feature test tasks.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic       mem_read, mem_to_reg, mem_write, reg_write, jump, illegal;
  logic [1:0] ALU_op;
  logic [5:0] op_code;
  logic [5:0] funct;

  // Vector layout: {mem_read, mem_to_reg, mem_write, reg_write, jump, alu_op[1:0], illegal}
  logic [7:0] out_vec;
  assign out_vec = {mem_read, mem_to_reg, mem_write, reg_write, jump, ALU_op, illegal};

  logic [7:0] exp_q[$];
  logic [7:0] op_table[logic [5:0]];
  logic [5:0] legal_funct[$];
  int pass_cnt;
  int total_cnt;

  localparam logic [7:0] V_ZERO    = 8'b0000_0000;
  localparam logic [7:0] V_RTYPE   = 8'b0001_0100;
  localparam logic [7:0] V_LW      = 8'b1101_0000;
  localparam logic [7:0] V_SW      = 8'b0010_0000;
  localparam logic [7:0] V_BEQ     = 8'b0000_0010;
  localparam logic [7:0] V_J       = 8'b0000_1000;
  localparam logic [7:0] V_ILLEGAL = 8'b0000_0001;

  control_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_read   (mem_read),
    .mem_to_reg (mem_to_reg),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .jump       (jump),
    .ALU_op     (ALU_op),
    .illegal    (illegal),
    .op_code    (op_code),
    .funct      (funct)
  );

  // clock/reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rst_n   = 1'b0;
    op_code = 6'h00;
    funct   = 6'h00;
  end

  function automatic logic [7:0] ref_decode(input logic [5:0] op, input logic [5:0] fn);
    if (op == 6'h00) begin
      foreach (legal_funct[i]) if (legal_funct[i] == fn) return V_RTYPE;
      return V_ILLEGAL;
    end
    if (op_table.exists(op)) return op_table[op];
    return V_ILLEGAL;
  endfunction

  // driver: applies one instruction at the falling edge, queues its expectation,
  // and returns just after the rising edge that registers it
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic rst);
    @(negedge clk);
    op_code = op;
    funct   = fn;
    rst_n   = rst;
    exp_q.push_back(rst ? ref_decode(op, fn) : V_ZERO);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [7:0] e;
    for (int i = 0; i < 2; i++) begin
      drive(6'h23, 6'($urandom_range(0, 63)), 1'b0);
      e = exp_q.pop_front();
      total_cnt++;
      if (out_vec !== e) $display("FAIL reset_hold[%0d] got=%b exp=%b", i, out_vec, e);
      else pass_cnt++;
    end
    drive(6'h23, 6'bxxxxxx, 1'b1);
    e = exp_q.pop_front();
    total_cnt++;
    if (out_vec !== e || $isunknown(out_vec)) $display("FAIL reset_release_lw got=%b exp=%b", out_vec, e);
    else pass_cnt++;
  endtask

  task automatic test_rtype;
    logic [7:0] e;
    logic [5:0] fns[2];
    fns[0] = 6'd32;
    fns[1] = 6'd34;
    foreach (fns[i]) begin
      drive(6'h00, fns[i], 1'b1);
      e = exp_q.pop_front();
      total_cnt++;
      if (out_vec !== e) $display("FAIL rtype_funct_%0d got=%b exp=%b", fns[i], out_vec, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_mem_branch_jump;
    logic [7:0] e;
    logic [5:0] ops[4];
    ops[0] = 6'd35; ops[1] = 6'd43; ops[2] = 6'd2; ops[3] = 6'd4;
    foreach (ops[i]) begin
      drive(ops[i], 6'bxxxxxx, 1'b1);
      e = exp_q.pop_front();
      total_cnt++;
      if (out_vec !== e || $isunknown(out_vec))
        $display("FAIL opcode_%0d got=%b exp=%b", ops[i], out_vec, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_illegal;
    logic [7:0] e;
    drive(6'h3F, 6'($urandom_range(0, 63)), 1'b1);
    e = exp_q.pop_front();
    total_cnt++;
    if (out_vec !== e) $display("FAIL illegal_op got=%b exp=%b", out_vec, e);
    else pass_cnt++;
    drive(6'h00, 6'h3F, 1'b1);
    e = exp_q.pop_front();
    total_cnt++;
    if (out_vec !== e) $display("FAIL illegal_funct got=%b exp=%b", out_vec, e);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] e;
    logic [5:0] ops[6];
    logic [5:0] fns[6];
    logic       rsts[6];
    ops[0] = 6'h00; fns[0] = 6'h20; rsts[0] = 1'b1;
    ops[1] = 6'h23; fns[1] = 6'h11; rsts[1] = 1'b1;
    ops[2] = 6'h2B; fns[2] = 6'h20; rsts[2] = 1'b1;
    ops[3] = 6'h02; fns[3] = 6'h2A; rsts[3] = 1'b1;
    ops[4] = 6'h00; fns[4] = 6'h24; rsts[4] = 1'b0;
    ops[5] = 6'h04; fns[5] = 6'h25; rsts[5] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(ops[i], fns[i], rsts[i]);
      e = exp_q.pop_front();
      total_cnt++;
      if (out_vec !== e) $display("FAIL b2b_step%0d got=%b exp=%b", i, out_vec, e);
      else pass_cnt++;
    end
  endtask

  task automatic test_random;
    logic [7:0] e;
    logic [5:0] op, fn;
    logic       rst;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0:       op = 6'h00;
        1:       op = 6'($urandom_range(0, 63));
        default: op = (($urandom_range(0, 1) == 0) ? 6'h23 : 6'h2B) ^ 6'($urandom_range(0, 1) * 6'h27);
      endcase
      fn  = ($urandom_range(0, 1) == 0) ? legal_funct[$urandom_range(0, 4)] : 6'($urandom_range(0, 63));
      rst = ($urandom_range(0, 15) != 0);
      drive(op, fn, rst);
      e = exp_q.pop_front();
      total_cnt++;
      if (out_vec !== e) $display("FAIL random[%0d] op=%h fn=%h rst_n=%b got=%b exp=%b", i, op, fn, rst, out_vec, e);
      else pass_cnt++;
      total_cnt++;
      if ((mem_read && mem_write) || (reg_write && (mem_write || jump)) ||
          (illegal && (mem_read || mem_write || reg_write || jump)))
        $display("FAIL safety[%0d] got=%b exp=no_conflict", i, out_vec);
      else pass_cnt++;
    end
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    op_table[6'h23] = V_LW;
    op_table[6'h2B] = V_SW;
    op_table[6'h04] = V_BEQ;
    op_table[6'h02] = V_J;
    legal_funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

    test_reset();
    test_rtype();
    test_mem_branch_jump();
    test_illegal();
    test_back_to_back();
    test_random();

    total_cnt++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    else pass_cnt++;

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
